// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants and clear-FSM state type for the register file
package reg_file_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/reg_file_clear_seq.sv
// rtl/reg_file_clear_seq.sv - sequential clear FSM: walks entries 0..N-1 after RESET
//
// Ports:
//   CLK, RESET  clock and synchronous active-high reset
//   busy        registered, high while the FSM is in CLEAR
//   clr_en      strobe: zero entry clr_addr at this edge
//   clr_addr    entry to zero (the clear counter)
module reg_file_clear_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int CLEAR_MODE = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic              busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLK) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    // RESET wins over an in-progress clear, so a reassertion restarts at entry 0.
    // In single-edge mode the FSM never leaves IDLE; the top clears everything at RESET.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        if (RESET) begin
            state_d = (CLEAR_MODE != 0) ? CLEAR : IDLE;
            cnt_d   = '0;
        end else if (state_q == CLEAR) begin
            clr_en = 1'b1;
            if (cnt_q == LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign busy     = (state_q == CLEAR);
    assign clr_addr = cnt_q;

endmodule

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parameterised 2-read/1-write register file with registered reads
//
// Ports:
//   CLK, RESET          clock and synchronous active-high reset
//   WRITEENABLE         write request
//   WRITEREG, WRITEDATA write address and data
//   READREG1, READREG2  read addresses
//   REGOUT1, REGOUT2    registered read data (write-through bypass)
//   BUSY                high while a sequential clear runs
//   WDROP               one-cycle pulse after a write refused because of BUSY
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int ZERO_REG   = 0,
    parameter int CLEAR_MODE = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WRITEENABLE,
    input  logic [ADDR_W-1:0] WRITEREG,
    input  logic [DATA_W-1:0] WRITEDATA,
    input  logic [ADDR_W-1:0] READREG1,
    input  logic [ADDR_W-1:0] READREG2,
    output logic [DATA_W-1:0] REGOUT1,
    output logic [DATA_W-1:0] REGOUT2,
    output logic              BUSY,
    output logic              WDROP
);

    localparam int N = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [N];
    logic              busy;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_zero;
    logic              wr_acc;
    logic [DATA_W-1:0] rd1_d, rd2_d;

    reg_file_clear_seq #(
        .ADDR_W     (ADDR_W),
        .CLEAR_MODE (CLEAR_MODE)
    ) u_clear_seq (
        .CLK      (CLK),
        .RESET    (RESET),
        .busy     (busy),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    // Writes to the hardwired-zero entry are silently discarded (no WDROP).
    assign wr_zero = (ZERO_REG != 0) && (WRITEREG == '0);
    assign wr_acc  = WRITEENABLE && !busy && !RESET && !wr_zero;

    always_comb begin
        rd1_d = mem[READREG1];
        rd2_d = mem[READREG2];
        if (wr_acc && (READREG1 == WRITEREG)) rd1_d = WRITEDATA;
        if (wr_acc && (READREG2 == WRITEREG)) rd2_d = WRITEDATA;
        if ((ZERO_REG != 0) && (READREG1 == '0)) rd1_d = '0;
        if ((ZERO_REG != 0) && (READREG2 == '0)) rd2_d = '0;
        // Mid-clear contents are a mix of old and zeroed data; hide them.
        if (busy) begin
            rd1_d = '0;
            rd2_d = '0;
        end
    end

    // clr_en and wr_acc never coincide: clr_en implies busy, which blocks writes.
    always_ff @(posedge CLK) begin
        if (RESET && (CLEAR_MODE == 0)) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc) begin
            mem[WRITEREG] <= WRITEDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            REGOUT1 <= '0;
            REGOUT2 <= '0;
            WDROP   <= 1'b0;
        end else begin
            REGOUT1 <= rd1_d;
            REGOUT2 <= rd2_d;
            WDROP   <= WRITEENABLE && busy;
        end
    end

    assign BUSY = busy;

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter DATA_W, default 8, register width in bits.
REQ-002 Parameter ADDR_W, default 3, address width; depth N = 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 0; 1 = entry 0 reads as zero and ignores writes.
REQ-004 Parameter CLEAR_MODE, default 0; 0 = single-edge clear, 1 = sequential clear, one entry per cycle.
REQ-005 CLK  input  1  clock; all state updates on rising edge.
REQ-006 RESET  input  1  reset, synchronous, active-high.
REQ-007 WRITEENABLE  input  1  write request, sampled at rising edge.
REQ-008 WRITEREG  input  ADDR_W  write address.
REQ-009 WRITEDATA  input  DATA_W  write data.
REQ-010 READREG1, READREG2  input  ADDR_W each  read addresses.
REQ-011 REGOUT1, REGOUT2  output  DATA_W each  registered read data.
REQ-012 BUSY  output  1  high while a clear is in progress.
REQ-013 WDROP  output  1  one-cycle pulse: a write was refused.

Function
REQ-014 Reads SHALL be registered, with 1-cycle latency: REGOUTx after edge k = entry[READREGx sampled at edge k].
REQ-015 Writes SHALL update entry[WRITEREG] at the edge where WRITEENABLE=1, BUSY=0 and RESET=0.
REQ-016 Bypass: at a given edge, if a write is accepted and READREGx == WRITEREG, REGOUTx SHALL take WRITEDATA, not the old entry.
REQ-017 Both read ports SHALL be independent; the same address on both ports gives identical data.
REQ-018 With ZERO_REG=1, writes to address 0 SHALL be ignored without asserting WDROP, and reads of address 0 SHALL return 0, bypass included.
REQ-019 CLEAR_MODE=0: at a RESET edge, all entries SHALL become 0 and BUSY SHALL stay 0.
REQ-020 CLEAR_MODE=1: the FSM has states IDLE and CLEAR.
  - A RESET edge enters CLEAR with counter cnt=0.
  - Each CLEAR edge with RESET=0 zeroes entry[cnt] and increments cnt.
  - The edge that clears entry N-1 returns the FSM to IDLE.
REQ-021 BUSY SHALL equal (state==CLEAR) and be registered; after RESET falls, BUSY SHALL stay high for exactly N cycles.
REQ-022 RESET asserted during CLEAR SHALL restart the clear with cnt=0.
REQ-023 A write request while BUSY=1 and RESET=0 SHALL be dropped, and WDROP SHALL pulse high for the following cycle.
REQ-024 Reads while BUSY=1 SHALL return 0 regardless of address.
REQ-025 A write request on a RESET edge SHALL be ignored and SHALL NOT assert WDROP.
REQ-026 cnt SHALL be ADDR_W bits wide; the terminal compare is cnt == N-1, with no wrap past N-1.

Reset
REQ-027 At a RESET edge: REGOUT1=0, REGOUT2=0, WDROP=0.
REQ-028 At a RESET edge: BUSY=0 when CLEAR_MODE=0, BUSY=1 when CLEAR_MODE=1.
REQ-029 Entry contents before the first RESET are undefined; the bench SHALL NOT check them.

Structure
REQ-030 Package reg_file_pkg SHALL hold the default DATA_W/ADDR_W constants and the clear-FSM state enum (IDLE, CLEAR).
REQ-031 Sub-module reg_file_clear_seq SHALL hold the clear FSM, cnt, BUSY and the clear-strobe/address outputs.
REQ-032 The storage array and read/bypass logic SHALL live in reg_file_param.

Verification
REQ-033 Defaults; RESET 1 cycle.
  - Stimulus: write 95 to reg 2; next cycle read READREG1=2.
  - Required: REGOUT1=95 one edge after the read address is applied.
REQ-034 Bypass.
  - Stimulus: in one cycle, write 28 to reg 1 with READREG1=1 and READREG2=1.
  - Required: REGOUT1=REGOUT2=28 after that same edge.
REQ-035 ZERO_REG=1.
  - Stimulus: write 50 to reg 0; read reg 0.
  - Required: REGOUT=0 and WDROP=0.
REQ-036 CLEAR_MODE=1, ADDR_W=3.
  - Stimulus: fill all 8 entries with 0xAA; pulse RESET.
  - Required: BUSY high exactly 8 cycles; afterwards every entry reads 0.
REQ-037 CLEAR_MODE=1.
  - Stimulus: write 6 to reg 4 during the 3rd BUSY cycle.
  - Required: WDROP pulses 1 cycle; reg 4 reads 0 after the clear.
REQ-038 CLEAR_MODE=1.
  - Stimulus: reassert RESET during the 5th BUSY cycle.
  - Required: cnt restarts; BUSY stays high 8 cycles after the second RESET falls.
